// File: rtl/commit_trace_tx.sv
// Retirement-trace transmitter: buffers one commit record per retired instruction and
// serializes it as 4..7 32-bit words over a valid/ready stream.
module commit_trace_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        commit_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] next_pc_i,
  input  logic        rf_we_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic [31:0] rf_wdata_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stall_o,
  output logic        tx_valid_o,
  output logic [31:0] tx_data_o,
  output logic        tx_last_o,
  input  logic        tx_ready_i,
  output logic        overflow_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        rfw;
    logic        memw;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic [31:0] mdata;
  } rec_t;

  typedef enum logic [2:0] {
    StIdle, StHdr, StPc, StIns, StNpc, StRfd, StMa, StMd
  } state_e;

  rec_t            mem_q [DEPTH];
  rec_t            head;
  rec_t            wr_rec;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      drop_q, drop_d;
  logic            ovf_q, ovf_d;
  state_e          state_q, state_d;

  logic full, empty, accept, last, push, pop, drop;

  assign full   = (cnt_q == CntW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign head   = mem_q[rptr_q];
  assign accept = tx_valid_o && tx_ready_i;
  assign pop    = accept && last;
  // A full FIFO still takes the new record when the head leaves on the same edge.
  assign push   = commit_i && (!full || pop);
  assign drop   = commit_i && full && !pop;

  always_comb begin
    wr_rec         = '0;
    wr_rec.seq     = seq_q;
    wr_rec.pc      = pc_i;
    wr_rec.instr   = instr_i;
    wr_rec.next_pc = next_pc_i;
    wr_rec.rfw     = rf_we_i && (rf_waddr_i != 5'd0);
    wr_rec.memw    = mem_we_i;
    wr_rec.waddr   = rf_waddr_i;
    wr_rec.wdata   = rf_wdata_i;
    wr_rec.maddr   = mem_addr_i;
    wr_rec.mdata   = mem_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wr_rec;
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    seq_d  = commit_i ? seq_q + 8'd1 : seq_q;
    ovf_d  = ovf_q || drop;
    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  // Serializer: next state plus word mux, all decoded from registered state and FIFO head.
  always_comb begin
    state_d    = state_q;
    tx_valid_o = 1'b1;
    tx_data_o  = '0;
    last       = 1'b0;
    case (state_q)
      StIdle: begin
        tx_valid_o = 1'b0;
        if (!empty) state_d = StHdr;
      end
      StHdr: begin
        tx_data_o = {8'hC0, head.seq, head.rfw, head.memw, head.waddr, 9'b0};
        if (accept) state_d = StPc;
      end
      StPc: begin
        tx_data_o = head.pc;
        if (accept) state_d = StIns;
      end
      StIns: begin
        tx_data_o = head.instr;
        if (accept) state_d = StNpc;
      end
      StNpc: begin
        tx_data_o = head.next_pc;
        last      = !head.rfw && !head.memw;
        if (accept) state_d = head.rfw ? StRfd : (head.memw ? StMa : StIdle);
      end
      StRfd: begin
        tx_data_o = head.wdata;
        last      = !head.memw;
        if (accept) state_d = head.memw ? StMa : StIdle;
      end
      StMa: begin
        tx_data_o = head.maddr;
        if (accept) state_d = StMd;
      end
      StMd: begin
        tx_data_o = head.mdata;
        last      = 1'b1;
      end
      default: begin
        tx_valid_o = 1'b0;
        state_d    = StIdle;
      end
    endcase
    if (pop) begin
      state_d = (cnt_q > CntW'(1)) ? StHdr : StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      state_q <= StIdle;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end

  assign tx_last_o  = last;
  assign stall_o    = full;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: hand-computed records, overflow, backpressure, reset.
module tb_commit_trace_tx;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_i = 1'b0;
  logic [31:0] pc_i = '0, instr_i = '0, next_pc_i = '0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_waddr_i = '0;
  logic [31:0] rf_wdata_i = '0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic        stall_o, tx_valid_o, tx_last_o, overflow_o;
  logic [31:0] tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  drop_cnt_o;

  int checks = 0;
  int passed = 0;

  logic [31:0] got_w[$];
  logic        got_l[$];
  logic        timed_out;
  logic [31:0] exp_w[$];
  logic        exp_l[$];

  always #5 clk_i = ~clk_i;

  commit_trace_tx #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .commit_i(commit_i), .pc_i(pc_i), .instr_i(instr_i),
    .next_pc_i(next_pc_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .rf_wdata_i(rf_wdata_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .stall_o(stall_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic apply_reset();
    rst_n = 1'b0; commit_i = 1'b0; tx_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic drive(input logic c, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] npc, input logic rwe, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mwe, input logic [31:0] ma,
                       input logic [31:0] md);
    commit_i = c; pc_i = pc; instr_i = ins; next_pc_i = npc; rf_we_i = rwe;
    rf_waddr_i = wa; rf_wdata_i = wd; mem_we_i = mwe; mem_addr_i = ma; mem_wdata_i = md;
  endtask

  // Gathers one record with ready held high; words are sampled at negedge.
  task automatic collect(input int max_cycles);
    got_w.delete(); got_l.delete(); timed_out = 1'b0;
    tx_ready_i = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (tx_valid_o) begin
        got_w.push_back(tx_data_o);
        got_l.push_back(tx_last_o);
      end
      @(negedge clk_i);
      if (got_l.size() > 0 && got_l[got_l.size()-1]) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({tx_valid_o, tx_data_o, tx_last_o, stall_o, overflow_o, drop_cnt_o} !== '0)
      $display("FAIL reset_outputs: got v=%b d=%h l=%b st=%b ov=%b dc=%0d want all 0",
               tx_valid_o, tx_data_o, tx_last_o, stall_o, overflow_o, drop_cnt_o);
    else passed++;
  endtask

  task automatic test_addi();
    logic [31:0] e [5];
    e = '{32'hC0008200, 32'h0, 32'h20010005, 32'h4, 32'h5};
    tx_ready_i = 1'b1;
    drive(1, 32'h0, 32'h20010005, 32'h4, 1, 5'd1, 32'h5, 0, 32'h0, 32'h0);
    @(negedge clk_i);
    commit_i = 1'b0;
    checks++;
    if (tx_valid_o !== 1'b0) $display("FAIL addi_latency_early: valid=%b want 0", tx_valid_o);
    else passed++;
    @(negedge clk_i);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 32'hC0008200)
      $display("FAIL addi_first_word: valid=%b data=%h want 1/C0008200", tx_valid_o, tx_data_o);
    else passed++;
    collect(20);
    checks++;
    if (timed_out || got_w.size() != 5)
      $display("FAIL addi_len: words=%0d timeout=%b want 5", got_w.size(), timed_out);
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_w[i] !== e[i] || got_l[i] !== (i == 4))
          $display("FAIL addi_w%0d: got %h last=%b want %h last=%b", i, got_w[i], got_l[i],
                   e[i], (i == 4));
        else passed++;
      end
    end
  endtask

  task automatic test_sw();
    logic [31:0] e [6];
    e = '{32'hC0014000, 32'h4, 32'hAC010010, 32'h8, 32'h10, 32'hDEADBEEF};
    drive(1, 32'h4, 32'hAC010010, 32'h8, 0, 5'd0, 32'h0, 1, 32'h10, 32'hDEADBEEF);
    @(negedge clk_i);
    commit_i = 1'b0;
    collect(20);
    checks++;
    if (timed_out || got_w.size() != 6)
      $display("FAIL sw_len: words=%0d timeout=%b want 6", got_w.size(), timed_out);
    else begin
      passed++;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_w[i] !== e[i] || got_l[i] !== (i == 5))
          $display("FAIL sw_w%0d: got %h last=%b want %h last=%b", i, got_w[i], got_l[i],
                   e[i], (i == 5));
        else passed++;
      end
    end
  endtask

  task automatic test_r0_write();
    drive(1, 32'h8, 32'h20000123, 32'hC, 1, 5'd0, 32'h123, 0, 32'h0, 32'h0);
    @(negedge clk_i);
    commit_i = 1'b0;
    collect(20);
    checks++;
    if (timed_out || got_w.size() != 4 || got_w[0] !== 32'hC0020000 || got_w[3] !== 32'hC ||
        got_l[3] !== 1'b1)
      $display("FAIL r0_record: words=%0d hdr=%h w3=%h want 4 words C0020000..0000000C",
               got_w.size(), (got_w.size() > 0) ? got_w[0] : 32'hx,
               (got_w.size() > 3) ? got_w[3] : 32'hx);
    else passed++;
  endtask

  task automatic test_overflow();
    apply_reset();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), 32'h104 + 32'(i * 4), 0, 5'd0,
            32'h0, 0, 32'h0, 32'h0);
      if (i == 4) begin
        checks++;
        if (stall_o !== 1'b1) $display("FAIL ovf_stall: stall=%b want 1", stall_o);
        else passed++;
      end
      @(negedge clk_i);
    end
    commit_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1 || drop_cnt_o !== 8'd1)
      $display("FAIL ovf_flags: ov=%b drop=%0d want 1/1", overflow_o, drop_cnt_o);
    else passed++;
    @(negedge clk_i);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 32'hC0000000 || tx_last_o !== 1'b0)
      $display("FAIL ovf_hold: v=%b d=%h l=%b want 1/C0000000/0", tx_valid_o, tx_data_o,
               tx_last_o);
    else passed++;
    for (int r = 0; r < 4; r++) begin
      collect(20);
      checks++;
      if (timed_out || got_w.size() != 4 || got_w[0] !== (32'hC0000000 | (32'(r) << 16)) ||
          got_w[1] !== 32'h100 + 32'(r * 4))
        $display("FAIL ovf_rec%0d: words=%0d hdr=%h want 4 words hdr %h", r, got_w.size(),
                 (got_w.size() > 0) ? got_w[0] : 32'hx, 32'hC0000000 | (32'(r) << 16));
      else passed++;
    end
    checks++;
    if (stall_o !== 1'b0 || overflow_o !== 1'b1)
      $display("FAIL ovf_after: stall=%b ov=%b want 0/1", stall_o, overflow_o);
    else passed++;
    drive(1, 32'h200, 32'h2000, 32'h204, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk_i);
    commit_i = 1'b0;
    collect(20);
    checks++;
    if (timed_out || got_w.size() != 4 || got_w[0] !== 32'hC0050000)
      $display("FAIL ovf_seq5: words=%0d hdr=%h want 4 words C0050000", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'hx);
    else passed++;
  endtask

  task automatic test_random_backpressure();
    int          issued, cycles;
    logic [7:0]  seq;
    logic        pv, pr, pl, rfw;
    logic [31:0] pd, pc, ins, npc, wd, ma, md;
    logic [4:0]  wa;
    int          kind;
    apply_reset();
    exp_w.delete(); exp_l.delete();
    issued = 0; cycles = 0; seq = 8'd0; pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
    while ((issued < 50 || exp_w.size() != 0 || tx_valid_o) && cycles < 3000) begin
      if (pv && !pr) begin
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== pd || tx_last_o !== pl)
          $display("FAIL rnd_stable: v=%b d=%h l=%b want 1/%h/%b", tx_valid_o, tx_data_o,
                   tx_last_o, pd, pl);
        else passed++;
      end
      tx_ready_i = 1'($urandom % 2);
      if (tx_valid_o && tx_ready_i) begin
        checks++;
        if (exp_w.size() == 0)
          $display("FAIL rnd_extra: got %h want no word", tx_data_o);
        else if (tx_data_o !== exp_w[0] || tx_last_o !== exp_l[0])
          $display("FAIL rnd_word: got %h last=%b want %h last=%b", tx_data_o, tx_last_o,
                   exp_w[0], exp_l[0]);
        else passed++;
        if (exp_w.size() != 0) begin
          void'(exp_w.pop_front());
          void'(exp_l.pop_front());
        end
      end
      pv = tx_valid_o; pr = tx_ready_i; pd = tx_data_o; pl = tx_last_o;
      if (issued < 50 && !stall_o && ($urandom % 2) == 1) begin
        kind = int'($urandom % 4);
        pc = $urandom; ins = $urandom; npc = $urandom; wd = $urandom; ma = $urandom;
        md = $urandom; wa = 5'($urandom);
        drive(1, pc, ins, npc, kind[0], wa, wd, kind[1], ma, md);
        rfw = kind[0] && (wa != 5'd0);
        exp_w.push_back({8'hC0, seq, rfw, kind[1], wa, 9'b0}); exp_l.push_back(1'b0);
        exp_w.push_back(pc);  exp_l.push_back(1'b0);
        exp_w.push_back(ins); exp_l.push_back(1'b0);
        exp_w.push_back(npc); exp_l.push_back(!rfw && !kind[1]);
        if (rfw) begin
          exp_w.push_back(wd); exp_l.push_back(!kind[1]);
        end
        if (kind[1]) begin
          exp_w.push_back(ma); exp_l.push_back(1'b0);
          exp_w.push_back(md); exp_l.push_back(1'b1);
        end
        seq++;
        issued++;
      end else begin
        commit_i = 1'b0;
      end
      @(negedge clk_i);
      cycles++;
    end
    commit_i = 1'b0;
    checks++;
    if (cycles >= 3000 || issued != 50 || exp_w.size() != 0)
      $display("FAIL rnd_done: issued=%0d left=%0d cycles=%0d want 50/0/<3000", issued,
               exp_w.size(), cycles);
    else passed++;
  endtask

  task automatic test_reset_mid_record();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h40 + 32'(i), 32'hA0 + 32'(i), 32'h80 + 32'(i), 0, 5'd0, 32'h0, 0,
            32'h0, 32'h0);
      @(negedge clk_i);
    end
    commit_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (tx_data_o !== 32'hA0) $display("FAIL mid_w2: got %h want 000000a0", tx_data_o);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid_o, tx_data_o, tx_last_o, stall_o, overflow_o, drop_cnt_o} !== '0)
      $display("FAIL mid_reset_outputs: v=%b d=%h l=%b st=%b want all 0", tx_valid_o,
               tx_data_o, tx_last_o, stall_o);
    else passed++;
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (tx_valid_o !== 1'b0) $display("FAIL mid_no_partial: valid=%b want 0", tx_valid_o);
    else passed++;
    drive(1, 32'h300, 32'h3000, 32'h304, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk_i);
    commit_i = 1'b0;
    collect(20);
    checks++;
    if (timed_out || got_w.size() != 4 || got_w[0] !== 32'hC0000000 || got_w[1] !== 32'h300)
      $display("FAIL mid_seq0: words=%0d hdr=%h want 4 words C0000000", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'hx);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sw();
    test_r0_write();
    test_overflow();
    test_random_backpressure();
    test_reset_mid_record();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
